mux_reg_arb: RTL and testbench
==============================

# mux_reg_arb

Parametrised successor to the single-bit registered 2:1 mux: selects one of `NCH` input channels of `DW` bits each and registers the result. Each channel and the output use a valid/ready handshake. A runtime mode chooses between an externally driven select and a round-robin arbiter. The block sits between multiple producer channels and a single downstream consumer. It sustains one transfer per cycle under backpressure.

## Interface
Parameters:
- `DW`, 8, data width per channel (>=1)
- `NCH`, 4, number of input channels (>=2)
- `SW`, `$clog2(NCH)`, channel index width (derived; do not override)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mode`  in  1  0 = fixed select via `sel`; 1 = round-robin
- `sel`  in  SW  channel index used when `mode`=0
- `in_data`  in  NCH*DW  channel i occupies bits [i*DW +: DW]
- `in_valid`  in  NCH  per-channel valid
- `in_ready`  out  NCH  per-channel ready; one-hot or zero
- `out_data`  out  DW  registered selected data
- `out_ch`  out  SW  index of the channel that supplied `out_data`
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  downstream accepts the beat

## Operation
- Load enable: `load = !out_valid || out_ready`. This is a combinational path from `out_ready`; there is no skid buffer.
- Grant when `mode`=0:
  - `gnt = sel`, and `gnt_vld = (sel < NCH) && in_valid[sel]`.
  - An out-of-range `sel` grants nothing and all `in_ready` stay 0.
- Grant when `mode`=1:
  - Scan channels `ptr`, `ptr+1`, … with wrap at NCH.
  - `gnt` is the first channel with `in_valid` set, and `gnt_vld` is true if any channel is valid.
- Ready:
  - `in_ready[i] = load && gnt_vld && (gnt == i)`.
  - Transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- On a transfer:
  - `out_data <= in_data[gnt]`, `out_ch <= gnt`, `out_valid <= 1`.
  - If `mode`=1, `ptr <= (gnt == NCH-1) ? 0 : gnt+1`.
- With no transfer, when `out_valid && out_ready`: `out_valid <= 0`; `out_data` and `out_ch` hold their values.
- When `out_valid && !out_ready`: all outputs hold, and all `in_ready` = 0.
- `ptr` changes only on transfers taken in `mode`=1. It holds while `mode`=0.
- Switching `mode` or `sel` takes effect on the grant computed in the same cycle. A beat already in the output register is unaffected.
- Producers must hold `in_data` and `in_valid` until accepted. The block does not check this.

## Timing
- Reset (asynchronous assert, synchronous release): `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0.
- While `rst_n`=0, all `in_ready` = 0.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput: 1 beat/cycle when `out_ready` is held at 1.
- Simultaneous drain and load: in the same cycle, the output beat is consumed and a new beat is accepted. `out_valid` stays 1 and the data updates.
- Round-robin fairness: with all NCH channels continuously valid, each is granted exactly once in every NCH consecutive transfers.
- Wrap: a grant of channel NCH-1 sets `ptr` to 0.
- Reset mid-stream: a held output beat is discarded, and no `in_ready` pulse occurs in the reset-release cycle unless `load` is true.

## Test plan
- Reset: drive `rst_n`=0 asynchronously mid-cycle with `out_valid`=1 -> `out_valid`, `out_data` and `out_ch` go to 0 without a clock edge. After release, the first accepted beat is on channel 0 in `mode`=1.
- Fixed select (NCH=4, DW=8): `mode`=0, `sel`=2, all valid, `in_data`={0x44,0x33,0x22,0x11}, `out_ready`=1 -> every cycle `out_data`=0x33 and `out_ch`=2, with only `in_ready[2]` high. With `sel`=5 (NCH=5 build), `sel`=7 -> no `in_ready` and `out_valid` drops after one cycle.
- Round-robin: `mode`=1, all four channels valid for 8 cycles -> `out_ch` sequence 0,1,2,3,0,1,2,3. With only channels 1 and 3 valid -> 1,3,1,3.
- Backpressure: `out_ready`=0 for 3 cycles with the output full -> `out_data` held stable, all `in_ready`=0, `ptr` unchanged. Raising `out_ready` -> next beat loaded in the same cycle the held beat drains.
- Mode switch: in `mode`=1 after granting channel 2 (`ptr`=3), switch to `mode`=0 with `sel`=0 for 2 beats, then back to `mode`=1 -> next round-robin grant is channel 3.

Source files
------------

// File: rtl/mux_reg_arb.sv
// mux_reg_arb
//   Registered NCH:1 channel multiplexer with a valid/ready handshake on every
//   input channel and on the output. The channel is picked either by an
//   external index (mode=0) or by a round-robin arbiter (mode=1). One beat can
//   be accepted per cycle while the downstream consumer keeps out_ready high.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous, active-low reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used when mode=0 (out-of-range grants nothing)
//   in_data    NCH packed channels, channel i at [i*DW +: DW]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered data of the last accepted beat
//   out_ch     channel index that supplied out_data
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the beat
module mux_reg_arb #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int SW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [DW-1:0]     out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    // NCH expressed one bit wider than an index so that range checks and the
    // wrap-around sum in the round-robin scan never overflow.
    localparam logic [SW:0]   NCH_W  = (SW+1)'(NCH);
    localparam logic [SW-1:0] LAST_CH = SW'(NCH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0] out_data_reg,  out_data_next;
    logic [SW-1:0] out_ch_reg,    out_ch_next;
    logic          out_valid_reg, out_valid_next;
    logic [SW-1:0] ptr_reg,       ptr_next;

    // ------------------------------------------------------------------
    // Channel unpacking
    // ------------------------------------------------------------------
    logic [DW-1:0] ch_data [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*DW +: DW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
    logic          load;
    logic          xfer;
    logic [SW-1:0] fx_gnt;
    logic          fx_vld;
    logic [SW-1:0] rr_gnt;
    logic          rr_vld;
    logic [SW-1:0] gnt;
    logic          gnt_vld;

    // The output register can take a new beat when it is empty or draining
    // this cycle; out_ready feeds straight through to in_ready.
    assign load = !out_valid_reg || out_ready;

    // Fixed select: in_valid[sel] is only meaningful for in-range indices,
    // the range test masks it otherwise.
    assign fx_gnt = sel;
    assign fx_vld = ({1'b0, sel} < NCH_W) && in_valid[sel];

    // Round-robin scan starting at ptr. Iterating from the far end down to
    // ptr lets the closest valid channel overwrite earlier candidates, so
    // the final value is the first valid channel in scan order.
    always_comb begin
        logic [SW:0] pos;
        rr_gnt = '0;
        rr_vld = 1'b0;
        pos    = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_reg} + (SW+1)'(k);
            if (pos >= NCH_W) begin
                pos = pos - NCH_W;
            end
            if (in_valid[pos[SW-1:0]]) begin
                rr_gnt = pos[SW-1:0];
                rr_vld = 1'b1;
            end
        end
    end

    assign gnt     = mode ? rr_gnt : fx_gnt;
    assign gnt_vld = mode ? rr_vld : fx_vld;
    assign xfer    = load && gnt_vld;

    // Ready is forced low while reset is held; outside reset it is one-hot
    // on the granted channel or zero.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = rst_n && xfer && (gnt == SW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        out_valid_next = out_valid_reg;
        ptr_next       = ptr_reg;
        if (xfer) begin
            out_data_next  = ch_data[gnt];
            out_ch_next    = gnt;
            out_valid_next = 1'b1;
            // The pointer only advances for round-robin grants so that a
            // stretch of fixed-select traffic resumes where arbitration left.
            if (mode) begin
                ptr_next = (gnt == LAST_CH) ? '0 : gnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            out_valid_reg <= out_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_reg_arb.sv
module tb_mux_reg_arb;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    // Second build with NCH=5 to reach an out-of-range select value.
    logic        mode5;
    logic [2:0]  sel5;
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_valid5;
    logic        out_ready5;

    int tests = 0;
    int fails = 0;

    logic [7:0] chdat [4];

    mux_reg_arb #(.DW(8), .NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_reg_arb #(.DW(8), .NCH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .out_data(out_data5), .out_ch(out_ch5), .out_valid(out_valid5),
        .out_ready(out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (out_valid)
            $display("[TB] beat ch=%0d data=0x%02h", out_ch, out_data);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] c, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".ch"},    32'(out_ch),    32'(c));
        chk({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        chdat[0] = 8'h11; chdat[1] = 8'h22; chdat[2] = 8'h33; chdat[3] = 8'h44;
        rst_n     = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid  = 4'hF;
        out_ready = 1'b0;
        mode5     = 1'b0;
        sel5      = 3'd0;
        in_data5  = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        in_valid5 = 5'h00;
        out_ready5 = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state, with channels valid: no ready may leak out.
        step();
        step();
        chk_out("reset", 1'b0, 2'd0, 8'h00);
        chk("reset.in_ready", 32'(in_ready), 32'h0);

        // Release between edges; round-robin starts at channel 0.
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rel.in_ready", 32'(in_ready), 32'h1);

        // Round-robin, all four valid: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr%0d.in_ready", k), 32'(in_ready), 32'(1 << (k % 4)));
            step();
            chk_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), chdat[k % 4]);
        end

        // Only channels 1 and 3 valid: 1,3,1,3.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("rr13_%0d", k), 1'b1, (k % 2 == 0) ? 2'd1 : 2'd3,
                    (k % 2 == 0) ? 8'h22 : 8'h44);
        end

        // Backpressure: held beat ch3/0x44, no ready anywhere.
        in_valid  = 4'hF;
        out_ready = 1'b0;
        #1;
        chk("bp.in_ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("bp%0d", k), 1'b1, 2'd3, 8'h44);
            chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'h0);
        end
        // Release: pointer still 0, new beat loads as the held one drains.
        out_ready = 1'b1;
        #1;
        chk("bp.rel.in_ready", 32'(in_ready), 32'h1);
        step();
        chk_out("bp.rel", 1'b1, 2'd0, 8'h11);

        // Mode switch: grant 1 then 2 (ptr=3), two fixed beats on sel=0.
        step();
        chk_out("ms.rr1", 1'b1, 2'd1, 8'h22);
        step();
        chk_out("ms.rr2", 1'b1, 2'd2, 8'h33);
        mode = 1'b0;
        sel  = 2'd0;
        #1;
        chk("ms.fx.in_ready", 32'(in_ready), 32'h1);
        step();
        chk_out("ms.fx0", 1'b1, 2'd0, 8'h11);
        step();
        chk_out("ms.fx1", 1'b1, 2'd0, 8'h11);
        mode = 1'b1;
        #1;
        chk("ms.back.in_ready", 32'(in_ready), 32'h8);
        step();
        chk_out("ms.back", 1'b1, 2'd3, 8'h44);

        // Fixed select sel=2.
        mode = 1'b0;
        sel  = 2'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("fx2_%0d.in_ready", k), 32'(in_ready), 32'h4);
            step();
            chk_out($sformatf("fx2_%0d", k), 1'b1, 2'd2, 8'h33);
        end

        // Drain with nothing valid: valid drops, data and channel hold.
        in_valid = 4'h0;
        step();
        chk_out("drain", 1'b0, 2'd2, 8'h33);

        // Out-of-range select on the NCH=5 build.
        in_valid5 = 5'h1F;
        sel5      = 3'd1;
        step();
        chk("n5.sel1.valid", 32'(out_valid5), 32'h1);
        chk("n5.sel1.ch",    32'(out_ch5),    32'h1);
        chk("n5.sel1.data",  32'(out_data5),  32'h22);
        sel5 = 3'd7;
        #1;
        chk("n5.sel7.in_ready", 32'(in_ready5), 32'h0);
        step();
        chk("n5.sel7.valid", 32'(out_valid5), 32'h0);
        sel5 = 3'd4;
        #1;
        chk("n5.sel4.in_ready", 32'(in_ready5), 32'h10);
        step();
        chk("n5.sel4.data", 32'(out_data5), 32'h55);
        in_valid5 = 5'h00;

        // Asynchronous reset mid-cycle with a held beat and ptr=2.
        mode     = 1'b1;
        in_valid = 4'b0010;
        step();
        chk_out("pre_rst", 1'b1, 2'd1, 8'h22);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 8'h00);
        chk("async_rst.in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'h1);
        step();
        chk_out("post_rst", 1'b1, 2'd0, 8'h11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
